// File: rtl/serial_divider_controller.sv
// rtl/serial_divider_controller.sv - multi-cycle restoring divider with start/busy/done handshake
// Optional DIVZERO_SHORTCUT_EN: a zero divisor completes on the accepting edge without iterating.
module serial_divider_controller #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_w_q, rem_w_d;
  logic [WIDTH-1:0] q_w_q, q_w_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] q_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_w_q     <= '0;
      q_w_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_w_q     <= rem_w_d;
      q_w_q       <= q_w_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // One restoring step: partial keeps its top bit because 2*rem+1 can overflow WIDTH bits.
  always_comb begin
    partial        = {rem_w_q, dvd_q[cnt_q]};
    diff           = {1'b0, partial} - {2'b00, dvs_q};
    borrow         = diff[WIDTH+1];
    rem_step       = borrow ? partial[WIDTH-1:0] : WIDTH'(diff);
    q_step         = q_w_q;
    q_step[cnt_q]  = ~borrow;
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_w_d     = rem_w_q;
    q_w_d       = q_w_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_w_d = '0;
          q_w_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_CALC;
`ifdef DIVZERO_SHORTCUT_EN
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_w_d = rem_step;
        q_w_d   = q_step;
        if (cnt_q == '0) begin
          quotient_d  = q_step;
          remainder_d = rem_step;
          dbz_d       = (dvs_q == '0);
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider_controller.sv
// tb/tb_serial_divider_controller.sv - scoreboard bench for serial_divider_controller
module tb_serial_divider_controller;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  serial_divider_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic int exp_cycles(input logic [W-1:0] b);
`ifdef DIVZERO_SHORTCUT_EN
    if (b == 0) return 1;
`endif
    return W + 1;
  endfunction

  // Every done cycle retires exactly one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("busy_and_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", {28'd0, quotient}, {28'd0, e.q});
        check("remainder", {28'd0, remainder}, {28'd0, e.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        last_q = e.q;
        last_r = e.r;
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts sampled cycles after the accepting edge until done; busy must cover all earlier ones.
  task automatic wait_done(input int exp_n, input int already);
    int n;
    n = already;
    while (1) begin
      @(negedge clk);
      n++;
      check("busy", {31'd0, busy}, (n < exp_n) ? 32'd1 : 32'd0);
      if (done) begin
        check("latency", n, exp_n);
        return;
      end
      if (n > exp_n + 4) begin
        check("done_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_done(exp_cycles(b), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {28'd0, quotient}, 32'd0);
    check("rst_r", {28'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(4'd13, 4'd3);
    run(4'd15, 4'd1);
    run(4'd2, 4'd9);
    run(4'd9, 4'd0);

    // start during CALC must be ignored and held outputs must not move
    issue(4'd12, 4'd5);
    @(negedge clk);
    check("hold_q1", {28'd0, quotient}, {28'd0, last_q});
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    check("hold_q2", {28'd0, quotient}, {28'd0, last_q});
    check("hold_r2", {28'd0, remainder}, {28'd0, last_r});
    wait_done(W + 1, 2);

    // abandoned divide: asynchronous reset mid-CALC, no done afterwards
    @(negedge clk);
    start = 1'b1; dividend = 4'd10; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_q", {28'd0, quotient}, 32'd0);
    check("arst_r", {28'd0, remainder}, 32'd0);
    check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      check("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    run(4'd14, 4'd4);

    // exhaustive back-to-back sweep, each start issued in the previous DONE cycle
    for (int i = 0; i < 256; i++) begin
      run(W'(i >> 4), W'(i & 15));
    end

    @(negedge clk);
    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1);
  end

endmodule
